// File: rtl/prbs9_checker.sv
// ============================================================================
//  Module   : prbs9_checker
//  Purpose  : Self-synchronising checker for a 12-bit-per-word PRBS-9 stream
//             with lock FSM, per-word error strobe and saturating counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prbs9_checker #(
  parameter int LOCK_CNT = 4,
  parameter int MISS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [11:0]      DATA,
  input  logic             DVALID,
  input  logic             CLR,
  output logic             LOCKED,
  output logic             SYNCING,
  output logic             ERR,
  output logic [CNT_W-1:0] WERR_CNT,
  output logic [CNT_W-1:0] BERR_CNT
);

  localparam logic [1:0] c_HUNT   = 2'd0;
  localparam logic [1:0] c_SYNC   = 2'd1;
  localparam logic [1:0] c_LOCKED = 2'd2;

  localparam logic [4:0] c_LOCK_CNT = 5'(LOCK_CNT);
  localparam logic [4:0] c_MISS_CNT = 5'(MISS_CNT);

  // Twelve serial steps of the PRBS-9 LFSR give the next whole word.
  function automatic logic [11:0] prbsNext(input logic [11:0] w);
    logic [11:0] t;
    t = w;
    for (int i = 0; i < 12; i++) begin
      t = {t[10:0], t[4] ^ t[8]};
    end
    return t;
  endfunction

  logic [1:0]       r_state;
  logic [1:0]       w_stateNext;
  logic [3:0]       r_matchCnt;
  logic [3:0]       w_matchCntNext;
  logic [3:0]       r_missCnt;
  logic [3:0]       w_missCntNext;
  logic [11:0]      r_exp;
  logic             r_err;
  logic [CNT_W-1:0] r_werrCnt;
  logic [CNT_W-1:0] r_berrCnt;

  logic [11:0]      w_xor;
  logic [3:0]       w_diff;
  logic             w_match;
  logic             w_err;
  logic [CNT_W-1:0] w_werrInc;
  logic [CNT_W:0]   w_berrSum;
  logic [CNT_W-1:0] w_berrInc;

  always_comb begin
    w_xor   = DATA ^ r_exp;
    w_match = (w_xor == 12'd0);
    w_diff  = 4'd0;
    for (int i = 0; i < 12; i++) begin
      w_diff = w_diff + {3'd0, w_xor[i]};
    end
    w_err = DVALID && (r_state == c_LOCKED) && !w_match;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= c_HUNT;
      r_matchCnt <= 4'd0;
      r_missCnt  <= 4'd0;
    end else begin
      r_state    <= w_stateNext;
      r_matchCnt <= w_matchCntNext;
      r_missCnt  <= w_missCntNext;
    end
  end

  // Next-state logic; only accepted words move the FSM.
  always_comb begin
    w_stateNext    = r_state;
    w_matchCntNext = r_matchCnt;
    w_missCntNext  = r_missCnt;
    if (DVALID) begin
      case (r_state)
        c_HUNT: begin
          if (DATA != 12'd0) begin
            w_stateNext    = c_SYNC;
            w_matchCntNext = 4'd0;
          end
        end
        c_SYNC: begin
          if (w_match && (DATA != 12'd0)) begin
            if (({1'b0, r_matchCnt} + 5'd1) == c_LOCK_CNT) begin
              w_stateNext   = c_LOCKED;
              w_missCntNext = 4'd0;
            end else begin
              w_matchCntNext = r_matchCnt + 4'd1;
            end
          end else begin
            w_stateNext = c_HUNT;
          end
        end
        c_LOCKED: begin
          if (w_match) begin
            w_missCntNext = 4'd0;
          end else if (({1'b0, r_missCnt} + 5'd1) == c_MISS_CNT) begin
            w_stateNext = c_HUNT;
          end else begin
            w_missCntNext = r_missCnt + 4'd1;
          end
        end
        default: w_stateNext = c_HUNT;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    LOCKED   = (r_state == c_LOCKED);
    SYNCING  = (r_state == c_SYNC);
    ERR      = r_err;
    WERR_CNT = r_werrCnt;
    BERR_CNT = r_berrCnt;
  end

  always_comb begin
    w_werrInc = (&r_werrCnt) ? r_werrCnt : r_werrCnt + 1'b1;
    w_berrSum = {1'b0, r_berrCnt} + (CNT_W+1)'(w_diff);
    w_berrInc = w_berrSum[CNT_W] ? {CNT_W{1'b1}} : w_berrSum[CNT_W-1:0];
  end

  // Predictor is re-seeded from every accepted word, so a single bad word
  // costs at most two mismatches.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_exp     <= 12'd0;
      r_err     <= 1'b0;
      r_werrCnt <= '0;
      r_berrCnt <= '0;
    end else begin
      if (DVALID) begin
        r_exp <= prbsNext(DATA);
      end
      r_err <= w_err;
      if (CLR) begin
        r_werrCnt <= w_err ? CNT_W'(1) : '0;
        r_berrCnt <= w_err ? CNT_W'(w_diff) : '0;
      end else if (w_err) begin
        r_werrCnt <= w_werrInc;
        r_berrCnt <= w_berrInc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prbs9_checker.sv
// ============================================================================
//  Module   : tb_prbs9_checker
//  Purpose  : Scoreboard bench for prbs9_checker (8-bit counters).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prbs9_checker;

  localparam int LOCK_CNT = 4;
  localparam int MISS_CNT = 3;
  localparam int CNT_W    = 8;

  typedef struct packed {
    logic             locked;
    logic             syncing;
    logic             err;
    logic [CNT_W-1:0] werr;
    logic [CNT_W-1:0] berr;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [11:0]      DATA;
  logic             DVALID;
  logic             CLR;
  logic             LOCKED;
  logic             SYNCING;
  logic             ERR;
  logic [CNT_W-1:0] WERR_CNT;
  logic [CNT_W-1:0] BERR_CNT;

  prbs9_checker #(
    .LOCK_CNT(LOCK_CNT),
    .MISS_CNT(MISS_CNT),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .DATA    (DATA),
    .DVALID  (DVALID),
    .CLR     (CLR),
    .LOCKED  (LOCKED),
    .SYNCING (SYNCING),
    .ERR     (ERR),
    .WERR_CNT(WERR_CNT),
    .BERR_CNT(BERR_CNT)
  );

  always #5 CLK = ~CLK;

  int   nChecks = 0;
  int   nPass   = 0;
  exp_t scb[$];

  // Reference model state
  int               mState = 0;
  int               mMc    = 0;
  int               mXc    = 0;
  logic [11:0]      mExp   = 12'd0;
  logic [CNT_W-1:0] mWerr  = '0;
  logic [CNT_W-1:0] mBerr  = '0;
  logic             mErr   = 1'b0;
  logic [11:0]      txW    = 12'd0;

  function automatic logic [11:0] prbsNext(input logic [11:0] w);
    logic [11:0] t;
    t = w;
    for (int i = 0; i < 12; i++) t = {t[10:0], t[4] ^ t[8]};
    return t;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else nPass++;
  endtask

  task automatic modelStep(input logic [11:0] d, input logic v, input logic c, input logic rn);
    logic match;
    int   diff;
    logic e;
    if (!rn) begin
      mState = 0; mMc = 0; mXc = 0; mExp = 12'd0;
      mWerr = '0; mBerr = '0; mErr = 1'b0;
    end else begin
      e = 1'b0;
      diff = 0;
      if (v) begin
        match = (d == mExp);
        diff  = $countones(d ^ mExp);
        e     = (mState == 2) && !match;
        case (mState)
          0: if (d != 12'd0) begin mState = 1; mMc = 0; end
          1: begin
            if (match && d != 12'd0) begin
              if (mMc + 1 == LOCK_CNT) begin mState = 2; mXc = 0; end
              else mMc++;
            end else mState = 0;
          end
          default: begin
            if (match) mXc = 0;
            else if (mXc + 1 == MISS_CNT) mState = 0;
            else mXc++;
          end
        endcase
        mExp = prbsNext(d);
      end
      if (c) begin
        mWerr = e ? CNT_W'(1) : '0;
        mBerr = e ? CNT_W'(diff) : '0;
      end else if (e) begin
        if (mWerr != {CNT_W{1'b1}}) mWerr = mWerr + 1'b1;
        if (int'(mBerr) + diff > (1 << CNT_W) - 1) mBerr = {CNT_W{1'b1}};
        else mBerr = CNT_W'(int'(mBerr) + diff);
      end
      mErr = e;
    end
  endtask

  // Drive one cycle, push the model's expectation, then pop it against the DUT.
  task automatic drive(input logic [11:0] d, input logic v, input logic c, input logic rn);
    exp_t e;
    exp_t got;
    DATA = d; DVALID = v; CLR = c; RST_N = rn;
    modelStep(d, v, c, rn);
    scb.push_back('{locked: (mState == 2), syncing: (mState == 1), err: mErr, werr: mWerr, berr: mBerr});
    @(posedge CLK);
    #1;
    if (scb.size() == 0) begin
      checkVal("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e   = scb.pop_front();
      got = '{locked: LOCKED, syncing: SYNCING, err: ERR, werr: WERR_CNT, berr: BERR_CNT};
      checkVal("LOCKED",   32'(got.locked),  32'(e.locked));
      checkVal("SYNCING",  32'(got.syncing), 32'(e.syncing));
      checkVal("ERR",      32'(got.err),     32'(e.err));
      checkVal("WERR_CNT", 32'(got.werr),    32'(e.werr));
      checkVal("BERR_CNT", 32'(got.berr),    32'(e.berr));
    end
  endtask

  task automatic sendWord(input logic [11:0] mask, input logic c);
    drive(txW ^ mask, 1'b1, c, 1'b1);
    txW = prbsNext(txW);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0; DATA = 12'd0; DVALID = 1'b0; CLR = 1'b0;
    drive(12'd0, 1'b0, 1'b0, 1'b0);
    drive(12'h5A5, 1'b1, 1'b1, 1'b0);

    // All-zero input keeps the FSM hunting
    for (int i = 0; i < 5; i++) drive(12'd0, 1'b1, 1'b0, 1'b1);
    checkVal("zero_hunt_sync", 32'(SYNCING), 32'd0);
    checkVal("zero_hunt_lock", 32'(LOCKED), 32'd0);

    // Clean acquisition from seed 0x001
    txW = 12'h001;
    checkVal("p_of_seed", 32'(prbsNext(txW)), 32'h08C);
    sendWord(12'd0, 1'b0);
    checkVal("sync_after_w1", 32'(SYNCING), 32'd1);
    for (int i = 0; i < 3; i++) sendWord(12'd0, 1'b0);
    checkVal("nolock_after_w4", 32'(LOCKED), 32'd0);
    sendWord(12'd0, 1'b0);
    checkVal("lock_after_w5", 32'(LOCKED), 32'd1);
    for (int i = 0; i < 5; i++) sendWord(12'd0, 1'b0);

    // One word with bits 0 and 5 flipped
    sendWord(12'h021, 1'b0);
    for (int i = 0; i < 4; i++) sendWord(12'd0, 1'b0);
    checkVal("flip_werr", 32'(WERR_CNT), 32'd2);
    checkVal("flip_berr", 32'(BERR_CNT), 32'(2 + $countones(prbsNext(12'h021))));
    checkVal("flip_locked", 32'(LOCKED), 32'd1);

    // DVALID gaps inside a locked stream
    for (int i = 0; i < 6; i++) begin
      sendWord(12'd0, 1'b0);
      for (int j = 0; j < 3; j++) drive(12'($urandom), 1'b0, 1'b0, 1'b1);
    end

    // CLR with a clean word
    sendWord(12'd0, 1'b1);
    checkVal("clr_werr", 32'(WERR_CNT), 32'd0);
    checkVal("clr_berr", 32'(BERR_CNT), 32'd0);

    // Three 0x555 words force loss of lock
    for (int i = 0; i < 3; i++) begin
      drive(12'h555, 1'b1, 1'b0, 1'b1);
      txW = prbsNext(txW);
    end
    checkVal("miss_unlock", 32'(LOCKED), 32'd0);
    checkVal("miss_werr", 32'(WERR_CNT), 32'd3);
    for (int i = 0; i < 4; i++) sendWord(12'd0, 1'b0);
    checkVal("relock_w4", 32'(LOCKED), 32'd0);
    sendWord(12'd0, 1'b0);
    checkVal("relock_w5", 32'(LOCKED), 32'd1);

    // CLR coincident with an error
    sendWord(12'h100, 1'b1);
    checkVal("clr_err_werr", 32'(WERR_CNT), 32'd1);
    sendWord(12'd0, 1'b0);
    sendWord(12'd0, 1'b0);

    // Saturation: two errors per three words keeps lock
    for (int i = 0; i < 150; i++) begin
      sendWord(12'(1 << (i % 12)), 1'b0);
      sendWord(12'd0, 1'b0);
      sendWord(12'd0, 1'b0);
    end
    checkVal("sat_werr", 32'(WERR_CNT), 32'hFF);
    checkVal("sat_berr", 32'(BERR_CNT), 32'hFF);
    checkVal("sat_locked", 32'(LOCKED), 32'd1);

    // Reset mid-lock
    drive(txW, 1'b1, 1'b0, 1'b0);
    txW = prbsNext(txW);
    checkVal("rst_locked", 32'(LOCKED), 32'd0);
    checkVal("rst_werr", 32'(WERR_CNT), 32'd0);
    for (int i = 0; i < 4; i++) sendWord(12'd0, 1'b0);
    checkVal("rst_relock_w4", 32'(LOCKED), 32'd0);
    sendWord(12'd0, 1'b0);
    checkVal("rst_relock_w5", 32'(LOCKED), 32'd1);

    // Random traffic: gaps, sporadic corruption and clears
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) drive(12'($urandom), 1'b0, 1'b0, 1'b1);
      else if (r < 25) sendWord(12'($urandom_range(1, 4095)), 1'b0);
      else sendWord(12'd0, (r == 99));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prbs9_checker.md
Name: prbs9_checker

Overview:
- Receive-side companion to the 12-bit PRBS-9 word generator used for ADC/link test patterns.
- Consumes one 12-bit word per valid cycle and self-synchronises to the PRBS-9 sequence.
- Verifies every following word against the predicted next word.
- Reports lock state, per-word error strobes and saturating word/bit error counters to slow control.

Parameters:
LOCK_CNT, 4, consecutive matching words needed to go from SYNC to LOCKED (1..15)
MISS_CNT, 3, consecutive mismatching words in LOCKED that force return to HUNT (1..15)
CNT_W, 16, width of both error counters

Ports:
CLK  input  1  single system clock; all logic on rising edge
RST_N  input  1  synchronous active-low reset
DATA  input  12  received word under test
DVALID  input  1  DATA qualifier; words with DVALID=0 are ignored entirely (no state change)
CLR  input  1  synchronous clear of WERR_CNT/BERR_CNT; does not affect lock state
LOCKED  output  1  1 while FSM is in LOCKED
SYNCING  output  1  1 while FSM is in SYNC
ERR  output  1  one-cycle pulse: word mismatch detected while LOCKED
WERR_CNT  output  CNT_W  saturating count of mismatching words while LOCKED
BERR_CNT  output  CNT_W  saturating count of mismatching bits (popcount of XOR) while LOCKED

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is synchronous and active-low.
- Reset values (RST_N=0 at an edge): FSM=HUNT; LOCKED=0; SYNCING=0; ERR=0; WERR_CNT=0; BERR_CNT=0; predictor register EXP=0. Reset overrides CLR and DVALID. Reset mid-lock drops LOCKED on the next edge.
- Prediction function P(w): apply 12 times w := {w[10:0], w[4]^w[8]}, combinationally. Example: P(0x001)=0x08C. P(0x000)=0x000 (lockup word).
- Predictor register: on every accepted word (DVALID=1), EXP <= P(DATA), i.e. prediction is re-seeded from received data. A single corrupted word therefore yields at most 2 consecutive mismatches.
- Per accepted word: MATCH = (DATA == EXP). DIFF = popcount(DATA ^ EXP), 0..12.
- FSM, transitions only on accepted words:
  - HUNT: if DATA != 0 -> SYNC with match counter MC=0; otherwise stay. EXP is loaded either way.
  - SYNC: MATCH -> MC+1, and if MC+1 == LOCK_CNT -> LOCKED. Mismatch or DATA==0 -> HUNT.
  - LOCKED: MATCH -> miss counter XC=0. Mismatch -> XC+1, and if XC+1 == MISS_CNT -> HUNT. The mismatching word is still counted as an error.
- Errors (LOCKED only, including the word that causes exit to HUNT):
  - ERR=1 for exactly one cycle, registered, at the edge after the word's cycle.
  - WERR_CNT += 1 and BERR_CNT += DIFF, each saturating at all-ones (no wrap).
- No error is counted in HUNT or SYNC.
- CLR=1 with a simultaneous error: counters load the error contribution of that word (0->1 for WERR_CNT, 0->DIFF for BERR_CNT) rather than 0.
- Latency: LOCKED/SYNCING/ERR/counters all update at the edge following the accepted word. No combinational path from inputs to outputs.
- DVALID low for any number of cycles: all state held, ERR=0.

Test Plan:
- Reset, then feed a clean sequence seeded 0x001 (0x001, 0x08C, P(0x08C), ...) with DVALID=1 continuously -> SYNCING high after word 1; LOCKED high at edge after word 5 (LOCK_CNT=4); ERR never asserts; counters stay 0.
- Locked stream, flip bits 0 and 5 of one word -> 2 ERR pulses (that word and the next); WERR_CNT=2; BERR_CNT = DIFF(bad word) + DIFF(next word); LOCKED stays 1 (MISS_CNT=3).
- Locked stream, replace with 3 consecutive 0x555 words -> ERR on each; LOCKED drops after the third; WERR_CNT=3; a following clean sequence relocks after 1+4 words.
- All-zero input from reset -> FSM stays HUNT, SYNCING=0, LOCKED=0. Insert DVALID=0 gaps inside a clean locked stream -> no errors, lock held.
- Preload near saturation (force 2^CNT_W−2 errors, or use CNT_W=4) -> WERR_CNT sticks at all-ones. Assert CLR alone -> both counters 0. CLR together with an error -> WERR_CNT=1.
- RST_N=0 for one cycle while LOCKED with nonzero counters -> all outputs 0 at the next edge; relock requires a full HUNT/SYNC sequence.
